pipelined_add_sub: RTL and testbench



---
 rtl/pipelined_add_sub.sv | 98 +++++++++
 tb/tb_pipelined_add_sub.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor: the WIDTH-bit carry chain is cut
// into STAGES equal chunks, one register stage per chunk, valid/ready on both sides.
module pipelined_add_sub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int C   = WIDTH / STAGES;
    localparam int MSB = WIDTH - 1;

    logic              stall;
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_n;
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] c_n;
    logic [STAGES-1:0] ci;
    logic [WIDTH-1:0]  a_q    [STAGES];
    logic [WIDTH-1:0]  eb_q   [STAGES];
    logic [WIDTH-1:0]  s_q    [STAGES];
    logic [WIDTH-1:0]  a_src  [STAGES];
    logic [WIDTH-1:0]  eb_src [STAGES];
    logic [WIDTH-1:0]  s_src  [STAGES];
    logic [WIDTH-1:0]  s_n    [STAGES];
    logic              ovf_q;
    logic              ovf_n;

    assign stall    = v_q[STAGES-1] && !out_ready;
    assign in_ready = !stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [C:0] chunk;

        if (k == 0) begin : g_first
            assign a_src[k]  = a;
            assign eb_src[k] = sub ? ~b : b;
            assign s_src[k]  = '0;
            assign ci[k]     = sub ? ~cin : cin;
            assign v_n[k]    = in_valid;
        end else begin : g_rest
            assign a_src[k]  = a_q[k-1];
            assign eb_src[k] = eb_q[k-1];
            assign s_src[k]  = s_q[k-1];
            assign ci[k]     = c_q[k-1];
            assign v_n[k]    = v_q[k-1];
        end

        assign chunk  = {1'b0, a_src[k][k*C +: C]} + {1'b0, eb_src[k][k*C +: C]}
                      + {{C{1'b0}}, ci[k]};
        // Partial sums are zero above the chunks already done, so OR-in is a merge.
        assign s_n[k] = s_src[k] | (WIDTH'(chunk[C-1:0]) << (k*C));
        assign c_n[k] = chunk[C];
    end

    assign ovf_n = (a_src[STAGES-1][MSB] == eb_src[STAGES-1][MSB]) &&
                   (s_n[STAGES-1][MSB] != a_src[STAGES-1][MSB]);

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k]  <= '0;
                eb_q[k] <= '0;
                s_q[k]  <= '0;
            end
        end else if (!stall) begin
            v_q   <= v_n;
            c_q   <= c_n;
            ovf_q <= ovf_n;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k]  <= a_src[k];
                eb_q[k] <= eb_src[k];
                s_q[k]  <= s_n[k];
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign s         = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed bench for pipelined_add_sub: main 16/4 instance plus 16/1 and 32/8
// instances for the carry-wrap case; scoreboard checks streaming and backpressure.
module tb_pipelined_add_sub;

    logic        clk = 1'b0;
    logic        rst, in_valid, cin, sub, out_ready;
    logic [15:0] a, b;
    logic        in_ready, out_valid, cout, ovf;
    logic [15:0] s;
    logic        in_ready_1, out_valid_1, cout_1, ovf_1;
    logic [15:0] s_1;
    logic [31:0] a32, b32, s_w;
    logic        in_ready_w, out_valid_w, cout_w, ovf_w;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    logic [17:0] exp_q[$];
    int          acc_cyc[$];
    int          out_cyc[$];

    logic [15:0] va [8] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0000,
                            16'h7FFF, 16'hABCD, 16'h5555, 16'h00FF};
    logic [15:0] vb [8] = '{16'h4321, 16'hFFFF, 16'h8000, 16'h0001,
                            16'h8000, 16'h1234, 16'hAAAA, 16'hFF00};
    logic        vc [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        vs [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_add_sub #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf));

    pipelined_add_sub #(.WIDTH(16), .STAGES(1)) dut_1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_1),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_1),
        .out_ready(out_ready), .s(s_1), .cout(cout_1), .ovf(ovf_1));

    pipelined_add_sub #(.WIDTH(32), .STAGES(8)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .a(a32), .b(b32), .cin(cin), .sub(sub), .out_valid(out_valid_w),
        .out_ready(out_ready), .s(s_w), .cout(cout_w), .ovf(ovf_w));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
        end
    endtask

    // Reference from signed/unsigned integer arithmetic, returns {ovf, cout, s}.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic sb);
        int   sr, ur;
        logic c, o;
        if (sb) begin
            sr = $signed(x) - $signed(y) - int'(ci);
            ur = int'(x) - int'(y) - int'(ci);
            c  = (ur >= 0);
        end else begin
            sr = $signed(x) + $signed(y) + int'(ci);
            ur = int'(x) + int'(y) + int'(ci);
            c  = (ur > 65535);
        end
        o = (sr > 32767) || (sr < -32768);
        return {o, c, ur[15:0]};
    endfunction

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 64'(out_valid), 64'd0);
                end else begin
                    check("result", 64'({ovf, cout, s}), 64'(exp_q[0]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        out_cyc.push_back(cyc);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sub));
                acc_cyc.push_back(cyc);
            end
        end
    end

    task automatic do_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic ci, input logic sb,
                         input logic [15:0] es, input logic ec, input logic eo);
        a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_s"}, 64'(s), 64'(es));
        check({tag, "_cout"}, 64'(cout), 64'(ec));
        check({tag, "_ovf"}, 64'(ovf), 64'(eo));
    endtask

    // mode 0: always ready; 1: ready low for three cycles mid-burst; 2: toggling.
    task automatic run_stream(input int mode);
        int i = 0;
        int t = 0;
        acc_cyc.delete();
        out_cyc.delete();
        mon_en = 1'b1;
        while ((i < 8 || exp_q.size() != 0) && t < 100) begin
            case (mode)
                1:       out_ready = !(t >= 5 && t <= 7);
                2:       out_ready = (t % 2 == 0);
                default: out_ready = 1'b1;
            endcase
            in_valid = (i < 8);
            if (i < 8) begin
                a = va[i]; b = vb[i]; cin = vc[i]; sub = vs[i];
            end
            #3;
            if (mode == 1 && t >= 5 && t <= 7) check("stall_in_ready", 64'(in_ready), 64'd0);
            if (in_valid && in_ready) i++;
            @(posedge clk); #1;
            t++;
        end
        check("stream_done", 64'(i == 8 && exp_q.size() == 0), 64'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        mon_en    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        a32 = '0; b32 = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_s", 64'(s), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_valid_1", 64'(out_valid_1), 64'd0);
        check("rst_valid_w", 64'(out_valid_w), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rdy_after_rst", 64'(in_ready), 64'd1);
        check("rdy_after_rst_1", 64'(in_ready_1), 64'd1);
        check("rdy_after_rst_w", 64'(in_ready_w), 64'd1);

        // Carry wrap on all three configurations from one accepted operation.
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0;
        a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("wrap1_valid", 64'(out_valid_1), 64'd1);
        check("wrap1_s", 64'(s_1), 64'h0000);
        check("wrap1_cout", 64'(cout_1), 64'd1);
        check("wrap1_ovf", 64'(ovf_1), 64'd0);
        check("wrap4_early", 64'(out_valid), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("wrap4_valid", 64'(out_valid), 64'd1);
        check("wrap4_s", 64'(s), 64'h0000);
        check("wrap4_cout", 64'(cout), 64'd1);
        check("wrap4_ovf", 64'(ovf), 64'd0);
        check("wrap8_early", 64'(out_valid_w), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        check("wrap8_valid", 64'(out_valid_w), 64'd1);
        check("wrap8_s", 64'(s_w), 64'h0);
        check("wrap8_cout", 64'(cout_w), 64'd1);
        check("wrap8_ovf", 64'(ovf_w), 64'd0);
        a32 = '0; b32 = '0;

        do_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        do_op("borrow",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op("noborrow",16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);

        // Reset with three operations in flight and a fourth offered during reset.
        for (int k = 0; k < 3; k++) begin
            a = va[k]; b = vb[k]; cin = vc[k]; sub = vs[k]; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b1; a = 16'h1111; b = 16'h2222;
        @(posedge clk); #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_s", 64'(s), 64'd0);
        check("midrst_cout", 64'(cout), 64'd0);
        check("midrst_ovf", 64'(ovf), 64'd0);
        rst = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("post_rst_quiet", 64'(out_valid), 64'd0);
        end
        do_op("after_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        @(posedge clk); #1;

        run_stream(0);
        check("stream_latency", 64'(out_cyc[0] - acc_cyc[0]), 64'd4);
        check("stream_span", 64'(out_cyc[7] - out_cyc[0]), 64'd7);
        run_stream(1);
        run_stream(2);
        check("final_count", 64'(out_cyc.size()), 64'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
